// File: rtl/data_memory_arbiter.sv
// Two-port arbiter in front of a single-port data RAM.
// Port 0 is the CPU load/store unit, port 1 is the debug/loader DMA.
// Stores finish in the grant cycle. Loads hold the RAM for one extra
// cycle (RESP), so that the registered RAM output can be steered to the
// port that issued the load.
module data_memory_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int ARB_MODE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic [ADDR_W-1:0] data_memory_address,
  output logic [DATA_W-1:0] data_memory_data_in,
  output logic              store,
  output logic              load,
  input  logic [DATA_W-1:0] data_memory_data_out
);

  typedef enum logic {IDLE, RESP} state_t;

  state_t state_p1;
  state_t state_d;
  logic   last_grant_p1;  // port that received the most recent grant
  logic   owner_p1;       // port that owns the load currently in RESP
  logic   gnt0;
  logic   gnt1;

  // Arbitration: grants are only issued in IDLE and only to a port that is valid
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_p1 == IDLE) begin
      if (req0_valid && req1_valid) begin
        if (ARB_MODE != 0) begin
          gnt0 = 1'b1;
        end else if (last_grant_p1) begin
          gnt0 = 1'b1;
        end else begin
          gnt1 = 1'b1;
        end
      end else if (req0_valid) begin
        gnt0 = 1'b1;
      end else if (req1_valid) begin
        gnt1 = 1'b1;
      end
    end
  end

  // Next state, handshake and RAM-side drive; RAM outputs are zero outside a grant
  always_comb begin
    state_d             = state_p1;
    req0_ready          = 1'b0;
    req1_ready          = 1'b0;
    data_memory_address = '0;
    data_memory_data_in = '0;
    store               = 1'b0;
    load                = 1'b0;
    case (state_p1)
      IDLE: begin
        if (gnt0) begin
          req0_ready          = 1'b1;
          data_memory_address = req0_addr;
          data_memory_data_in = req0_wdata;
          store               = req0_we;
          load                = !req0_we;
          if (!req0_we) state_d = RESP;
        end else if (gnt1) begin
          req1_ready          = 1'b1;
          data_memory_address = req1_addr;
          data_memory_data_in = req1_wdata;
          store               = req1_we;
          load                = !req1_we;
          if (!req1_we) state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state: FSM, round-robin history and load ownership
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p1      <= IDLE;
      last_grant_p1 <= 1'b1;
      owner_p1      <= 1'b0;
    end else begin
      state_p1 <= state_d;
      if (gnt0 || gnt1) last_grant_p1 <= gnt1;
      if (load)         owner_p1      <= gnt1;
    end
  end

  // Response stage: capture RAM data for the owning port and pulse its valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_rdata <= '0;
      rsp1_rdata <= '0;
    end else begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      if (state_p1 == RESP) begin
        if (owner_p1) begin
          rsp1_valid <= 1'b1;
          rsp1_rdata <= data_memory_data_out;
        end else begin
          rsp0_valid <= 1'b1;
          rsp0_rdata <= data_memory_data_out;
        end
      end
    end
  end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter: one instance per arbitration mode, each with
// its own RAM, driven by a shared table, directed sequences and random traffic.
module tb_data_memory_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        v0 [2];
  logic        v1 [2];
  logic        we0 [2];
  logic        we1 [2];
  logic [11:0] a0 [2];
  logic [11:0] a1 [2];
  logic [31:0] d0 [2];
  logic [31:0] d1 [2];
  logic        rdy0 [2];
  logic        rdy1 [2];
  logic        rv0 [2];
  logic        rv1 [2];
  logic [31:0] rd0 [2];
  logic [31:0] rd1 [2];
  logic [11:0] maddr [2];
  logic [31:0] mdin [2];
  logic        st [2];
  logic        ld [2];

  for (genvar g = 0; g < 2; g++) begin : u
    logic [31:0] ram [4096];
    logic [31:0] dout;
    initial begin
      dout = '0;
      for (int i = 0; i < 4096; i++) ram[i] = '0;
    end
    always @(posedge clk) begin
      if (st[g]) ram[maddr[g]] <= mdin[g];
      if (ld[g]) dout <= ram[maddr[g]];
    end
    data_memory_arbiter #(.ADDR_W(12), .DATA_W(32), .ARB_MODE(g)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(v0[g]), .req0_ready(rdy0[g]), .req0_we(we0[g]),
      .req0_addr(a0[g]), .req0_wdata(d0[g]),
      .req1_valid(v1[g]), .req1_ready(rdy1[g]), .req1_we(we1[g]),
      .req1_addr(a1[g]), .req1_wdata(d1[g]),
      .rsp0_valid(rv0[g]), .rsp0_rdata(rd0[g]),
      .rsp1_valid(rv1[g]), .rsp1_rdata(rd1[g]),
      .data_memory_address(maddr[g]), .data_memory_data_in(mdin[g]),
      .store(st[g]), .load(ld[g]), .data_memory_data_out(dout)
    );
  end

  int n_tests;
  int n_fail;

  // Reference model state, index m = arbitration mode
  int          last_g [2];
  int          pend [2];        // port owning an outstanding load, -1 if none
  logic [11:0] pend_addr [2];
  logic [31:0] mm [2][4096];
  logic [1:0]  exp_rv [2];      // bit p = expected rsp_valid of port p
  logic [31:0] exp_rd [2][2];
  int          acc [2];         // port accepted in the last cycle, -1 if none
  int          rcnt [2][2];
  logic        rv1_seen;

  typedef struct {
    logic        v0, v1;
    logic [11:0] a0, a1;
    logic [31:0] d0, d1;
    logic [1:0]  e0, e1;        // expected {ready1, ready0} for mode 0 / mode 1
  } vec_t;
  vec_t tbl [9];

  function automatic vec_t mk(logic pv0, logic pv1, logic [11:0] pa0, logic [11:0] pa1,
                              logic [31:0] pd0, logic [31:0] pd1, logic [1:0] pe0, logic [1:0] pe1);
    vec_t r;
    r.v0 = pv0; r.v1 = pv1; r.a0 = pa0; r.a1 = pa1;
    r.d0 = pd0; r.d1 = pd1; r.e0 = pe0; r.e1 = pe1;
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_port(input int m, input int p, input logic v, input logic we,
                          input logic [11:0] a, input logic [31:0] d);
    if (p == 0) begin
      v0[m] = v; we0[m] = we; a0[m] = a; d0[m] = d;
    end else begin
      v1[m] = v; we1[m] = we; a1[m] = a; d1[m] = d;
    end
  endtask

  task automatic set_both(input int p, input logic v, input logic we,
                          input logic [11:0] a, input logic [31:0] d);
    for (int m = 0; m < 2; m++) set_port(m, p, v, we, a, d);
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      last_g[m] = 1;
      pend[m]   = -1;
      exp_rv[m] = 2'b00;
      exp_rd[m][0] = '0;
      exp_rd[m][1] = '0;
      acc[m] = -1;
    end
  endtask

  function automatic int winner(int m);
    if (pend[m] >= 0) return -1;
    if (v0[m] && v1[m]) return (m == 1) ? 0 : ((last_g[m] == 0) ? 1 : 0);
    if (v0[m]) return 0;
    if (v1[m]) return 1;
    return -1;
  endfunction

  task automatic check_model();
    for (int m = 0; m < 2; m++) begin
      int w;
      logic we;
      logic [11:0] ea;
      logic [31:0] ed;
      w  = winner(m);
      we = (w == 0) ? we0[m] : we1[m];
      ea = (w == 0) ? a0[m] : ((w == 1) ? a1[m] : 12'h000);
      ed = (w == 0) ? d0[m] : ((w == 1) ? d1[m] : 32'h0);
      chk($sformatf("model cycle mode%0d", m),
          {rdy0[m], rdy1[m], st[m], ld[m], maddr[m], mdin[m], rv0[m], rv1[m], rd0[m], rd1[m]},
          {w == 0, w == 1, (w >= 0) && we, (w >= 0) && !we, ea, ed,
           exp_rv[m][0], exp_rv[m][1], exp_rd[m][0], exp_rd[m][1]});
      rcnt[m][0] += int'(rdy0[m]);
      rcnt[m][1] += int'(rdy1[m]);
      rv1_seen = rv1_seen | rv1[m];
    end
  endtask

  task automatic update_model();
    for (int m = 0; m < 2; m++) begin
      int w;
      logic [1:0] nrv;
      w = winner(m);
      acc[m] = w;
      nrv = 2'b00;
      if (pend[m] >= 0) begin
        nrv[pend[m]] = 1'b1;
        exp_rd[m][pend[m]] = mm[m][pend_addr[m]];
        pend[m] = -1;
      end else if (w >= 0) begin
        logic [11:0] a;
        last_g[m] = w;
        a = (w == 0) ? a0[m] : a1[m];
        if ((w == 0) ? we0[m] : we1[m]) mm[m][a] = (w == 0) ? d0[m] : d1[m];
        else begin
          pend[m] = w;
          pend_addr[m] = a;
        end
      end
      exp_rv[m] = nrv;
    end
  endtask

  task automatic sample_edge();
    @(negedge clk);
  endtask

  task automatic finish_cycle();
    check_model();
    update_model();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_stim();
    for (int m = 0; m < 2; m++) begin
      for (int p = 0; p < 2; p++) begin
        logic cv;
        logic [11:0] a;
        cv = (p == 0) ? v0[m] : v1[m];
        if (cv && acc[m] != p) begin
          if ($urandom_range(0, 7) == 0) set_port(m, p, 1'b0, 1'b0, 12'h0, 32'h0);
        end else if ($urandom_range(0, 1) == 1) begin
          a = ($urandom_range(0, 7) == 0) ? 12'hfff : 12'($urandom_range(0, 15));
          set_port(m, p, 1'b1, 1'($urandom_range(0, 1)), a, $urandom);
        end else begin
          set_port(m, p, 1'b0, 1'b0, 12'h0, 32'h0);
        end
      end
    end
  endtask

  task automatic all_zero_check(input string name);
    for (int m = 0; m < 2; m++)
      chk(name, {rdy0[m], rdy1[m], st[m], ld[m], maddr[m], mdin[m], rv0[m], rv1[m], rd0[m], rd1[m]}, '0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent [2][2];
    int done_cyc0;
    int cyc;
    int order0 [$];

    n_tests = 0;
    n_fail  = 0;
    rv1_seen = 1'b0;
    tbl[0] = mk(0, 0, 12'h000, 12'h000, 32'h00, 32'h00, 2'b00, 2'b00);
    tbl[1] = mk(1, 1, 12'h001, 12'h002, 32'h11, 32'h22, 2'b01, 2'b01);
    tbl[2] = mk(1, 1, 12'h003, 12'h002, 32'h33, 32'h22, 2'b10, 2'b01);
    tbl[3] = mk(0, 1, 12'h003, 12'h002, 32'h33, 32'h22, 2'b10, 2'b10);
    tbl[4] = mk(1, 1, 12'h005, 12'h006, 32'h55, 32'h66, 2'b01, 2'b01);
    tbl[5] = mk(0, 1, 12'h005, 12'h006, 32'h55, 32'h66, 2'b10, 2'b10);
    tbl[6] = mk(1, 0, 12'hfff, 12'h006, 32'hffff_ffff, 32'h66, 2'b01, 2'b01);
    tbl[7] = mk(1, 1, 12'h008, 12'h009, 32'h88, 32'h99, 2'b10, 2'b01);
    tbl[8] = mk(0, 0, 12'h000, 12'h000, 32'h00, 32'h00, 2'b00, 2'b00);

    for (int m = 0; m < 2; m++)
      for (int i = 0; i < 4096; i++) mm[m][i] = '0;
    rst_n = 1'b0;
    set_both(0, 0, 0, 12'h0, 32'h0);
    set_both(1, 0, 0, 12'h0, 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    all_zero_check("reset state");
    rst_n = 1'b1;

    // Table of single-cycle store vectors
    for (int i = 0; i < 9; i++) begin
      set_both(0, tbl[i].v0, 1'b1, tbl[i].a0, tbl[i].d0);
      set_both(1, tbl[i].v1, 1'b1, tbl[i].a1, tbl[i].d1);
      sample_edge();
      for (int m = 0; m < 2; m++) begin
        logic [1:0] e;
        logic [11:0] ea;
        logic [31:0] ed;
        e  = (m == 0) ? tbl[i].e0 : tbl[i].e1;
        ea = e[0] ? tbl[i].a0 : (e[1] ? tbl[i].a1 : 12'h0);
        ed = e[0] ? tbl[i].d0 : (e[1] ? tbl[i].d1 : 32'h0);
        chk($sformatf("vector %0d mode%0d", i, m),
            {rdy0[m], rdy1[m], st[m], ld[m], maddr[m], mdin[m]},
            {e[0], e[1], |e, 1'b0, ea, ed});
      end
      finish_cycle();
    end

    // Write then read back on port 0
    set_both(0, 1, 1, 12'd123, 32'h1234_cdef);
    sample_edge();
    chk("t1 store with ready0", {rdy0[0], st[0], rdy0[1], st[1]}, 4'b1111);
    finish_cycle();
    set_both(0, 1, 0, 12'd123, 32'h0);
    sample_edge();
    finish_cycle();
    set_both(0, 0, 0, 12'h0, 32'h0);
    sample_edge();
    chk("t1 no response yet", {rv0[0], rv0[1]}, 2'b00);
    finish_cycle();
    sample_edge();
    chk("t1 load response", {rv0[0], rd0[0], rv0[1], rd0[1]},
        {1'b1, 32'h1234_cdef, 1'b1, 32'h1234_cdef});
    finish_cycle();

    // Boundary write from port 1, then port 0 read with port 1 store waiting
    set_both(1, 1, 1, 12'hfff, 32'hffff_ffff);
    sample_edge();
    finish_cycle();
    set_both(0, 1, 0, 12'hfff, 32'h0);
    set_both(1, 1, 1, 12'd5, 32'h55);
    rv1_seen = 1'b0;
    sample_edge();
    chk("t4 port0 load wins", {rdy0[0], rdy1[0], ld[0], rdy0[1], rdy1[1], ld[1]}, 6'b101101);
    finish_cycle();
    set_both(0, 0, 0, 12'h0, 32'h0);
    sample_edge();
    chk("t4 port1 waits in RESP", {rdy1[0], rdy1[1], st[0], st[1]}, 4'b0000);
    finish_cycle();
    sample_edge();
    chk("t4 port1 granted after RESP", {rdy1[0], rdy1[1], st[0], st[1]}, 4'b1111);
    chk("t5 boundary readback", {rv0[0], rd0[0], rv0[1], rd0[1]},
        {1'b1, 32'hffff_ffff, 1'b1, 32'hffff_ffff});
    finish_cycle();
    set_both(1, 0, 0, 12'h0, 32'h0);
    sample_edge();
    chk("idle RAM outputs", {st[0], ld[0], maddr[0], mdin[0], st[1], ld[1], maddr[1], mdin[1]}, '0);
    finish_cycle();
    chk("t4 no rsp1 pulse", rv1_seen, 1'b0);

    // Both ports issue four stores back-to-back
    for (int m = 0; m < 2; m++) begin
      sent[m][0] = 0; sent[m][1] = 0;
      rcnt[m][0] = 0; rcnt[m][1] = 0;
    end
    done_cyc0 = 0;
    cyc = 0;
    while (cyc < 20 && !(sent[0][0] == 4 && sent[0][1] == 4 && sent[1][0] == 4 && sent[1][1] == 4)) begin
      for (int m = 0; m < 2; m++)
        for (int p = 0; p < 2; p++)
          set_port(m, p, sent[m][p] < 4, 1'b1, 12'(16 + p * 4 + sent[m][p]),
                   32'hc000_0000 | (p << 8) | sent[m][p]);
      sample_edge();
      finish_cycle();
      for (int m = 0; m < 2; m++)
        if (acc[m] >= 0) sent[m][acc[m]]++;
      if (acc[0] >= 0) order0.push_back(acc[0]);
      cyc++;
      if (done_cyc0 == 0 && sent[0][0] == 4 && sent[0][1] == 4) done_cyc0 = cyc;
    end
    set_both(0, 0, 0, 12'h0, 32'h0);
    set_both(1, 0, 0, 12'h0, 32'h0);
    chk("t2 ready0 count", rcnt[0][0], 4);
    chk("t2 ready1 count", rcnt[0][1], 4);
    chk("t2 cycles for 8 stores", done_cyc0, 8);
    chk("t2 grant count", order0.size(), 8);
    for (int i = 0; i < order0.size() && i < 8; i++)
      chk($sformatf("t2 grant order %0d", i), order0[i], i % 2);

    // Fixed priority: port 0 valid continuously starves port 1
    rcnt[1][0] = 0;
    rcnt[1][1] = 0;
    set_both(0, 1, 1, 12'd200, 32'ha0);
    set_both(1, 1, 1, 12'd201, 32'ha1);
    repeat (10) begin
      sample_edge();
      finish_cycle();
    end
    chk("t3 ready1 held off", rcnt[1][1], 0);
    chk("t3 ready0 every cycle", rcnt[1][0], 10);
    set_both(0, 0, 0, 12'h0, 32'h0);
    sample_edge();
    chk("t3 port1 granted after drop", rdy1[1], 1'b1);
    finish_cycle();
    set_both(1, 0, 0, 12'h0, 32'h0);

    // Reset pulsed during RESP
    set_both(0, 1, 0, 12'd123, 32'h0);
    sample_edge();
    finish_cycle();
    set_both(0, 0, 0, 12'h0, 32'h0);
    rst_n = 1'b0;
    #1;
    model_reset();
    all_zero_check("t6 reset in RESP");
    @(posedge clk);
    #1;
    all_zero_check("t6 no pulse after reset");
    rst_n = 1'b1;
    set_both(0, 1, 1, 12'd300, 32'hb0);
    set_both(1, 1, 1, 12'd301, 32'hb1);
    sample_edge();
    chk("t6 tie after reset", {rdy0[0], rdy1[0], rdy0[1], rdy1[1]}, 4'b1010);
    finish_cycle();
    set_both(0, 0, 0, 12'h0, 32'h0);
    set_both(1, 0, 0, 12'h0, 32'h0);
    acc[0] = -1;
    acc[1] = -1;

    // Random traffic against the reference model
    repeat (3000) begin
      rand_stim();
      sample_edge();
      finish_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
